// File: rtl/avalon_st_sigma_delta_sink.sv
// Avalon-ST sample sink: FIFO buffer, audio-rate release, 1st-order sigma-delta DAC.
// Define DAC_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt port.
module avalon_st_sigma_delta_sink #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2083,
    parameter int DATA_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   asi_data,
    input  logic                          asi_valid,
    output logic                          asi_ready,
    input  logic                          i_clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun,
    output logic                          o_sample_tick,
    output logic                          o_dac_out
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   o_underrun_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [AW:0]       FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]     TICK_AT = CW'(CLK_DIV - 1);
    localparam logic [DATA_W-1:0] MSB     = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     div_cnt;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] acc;
    logic [DATA_W:0]   sum;
    logic              push;
    logic              pop;
    logic              underrun;
    logic              unused_bits;

    assign unused_bits = ^asi_data[31:DATA_W];

    assign asi_ready     = (o_level < FULL);
    assign o_sample_tick = (div_cnt == TICK_AT);
    assign push          = asi_valid && asi_ready;
    assign pop           = o_sample_tick && (o_level != '0);
    assign underrun      = o_sample_tick && (o_level == '0);

    // Offset-binary view of the signed sample feeds the accumulator.
    assign sum = {1'b0, acc} + {1'b0, sample ^ MSB};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asi_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   o_level <= o_level + 1'b1;
                2'b01:   o_level <= o_level - 1'b1;
                default: o_level <= o_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (o_sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // An empty FIFO at a tick plays midscale; a same-cycle push never falls through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample <= '0;
        end else if (pop) begin
            sample <= mem[rd_ptr];
        end else if (underrun) begin
            sample <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_underrun <= 1'b0;
        end else if (underrun) begin
            o_underrun <= 1'b1;
        end else if (i_clr_underrun) begin
            o_underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            o_dac_out <= 1'b0;
        end else begin
            acc       <= sum[DATA_W-1:0];
            o_dac_out <= sum[DATA_W];
        end
    end

`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0] cnt_base;

    // Clear applies before the increment, so clear+underrun yields 1.
    assign cnt_base = i_clr_underrun ? 16'h0000 : o_underrun_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_underrun_cnt <= '0;
        end else if (underrun && (cnt_base != 16'hFFFF)) begin
            o_underrun_cnt <= cnt_base + 16'h0001;
        end else begin
            o_underrun_cnt <= cnt_base;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_st_sigma_delta_sink.sv
// Scoreboard bench for avalon_st_sigma_delta_sink (CLK_DIV=64, FIFO_DEPTH=16).
// Reference model tracks FIFO contents, tick, underrun flag and the modulator.
module tb_avalon_st_sigma_delta_sink;

    localparam int DEPTH = 16;
    localparam int DIV   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] asi_data = '0;
    logic        asi_valid = 1'b0;
    logic        asi_ready;
    logic        clr = 1'b0;
    logic [4:0]  level;
    logic        underrun;
    logic        tick;
    logic        dac;
`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    always #5 clk = ~clk;

    avalon_st_sigma_delta_sink #(
        .FIFO_DEPTH(DEPTH),
        .CLK_DIV   (DIV),
        .DATA_W    (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .asi_data      (asi_data),
        .asi_valid     (asi_valid),
        .asi_ready     (asi_ready),
        .i_clr_underrun(clr),
        .o_level       (level),
        .o_underrun    (underrun),
        .o_sample_tick (tick),
        .o_dac_out     (dac)
`ifdef DAC_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt(ucnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] sb[$];
    int          m_cnt = 0;
    logic [15:0] m_sample = '0;
    logic [15:0] m_acc = '0;
    logic        m_dac = 1'b0;
    logic        m_und = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        logic        m_tick;
        logic        m_empty;
        logic        m_push;
        logic [16:0] s;
        if (!reset) begin
            sb.delete();
            m_cnt    = 0;
            m_sample = '0;
            m_acc    = '0;
            m_dac    = 1'b0;
            m_und    = 1'b0;
        end else begin
            m_tick  = (m_cnt == DIV - 1);
            m_empty = (sb.size() == 0);
            m_push  = asi_valid && (sb.size() < DEPTH);
            s       = {1'b0, m_acc} + {1'b0, m_sample ^ 16'h8000};
            m_acc   = s[15:0];
            m_dac   = s[16];
            if (m_tick && !m_empty) begin
                m_sample = sb.pop_front();
            end else if (m_tick) begin
                m_sample = '0;
            end
            if (m_tick && m_empty) begin
                m_und = 1'b1;
            end else if (clr) begin
                m_und = 1'b0;
            end
            if (m_push) begin
                sb.push_back(asi_data[15:0]);
            end
            m_cnt = m_tick ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        check("level", 32'(level), 32'(sb.size()));
        check("ready", asi_ready, sb.size() < DEPTH);
        check("tick", tick, m_cnt == DIV - 1);
        check("underrun", underrun, m_und);
        check("dac", dac, m_dac);
    end

    task automatic wait_tick_cycle();
        int n = 0;
        @(negedge clk);
        while (!tick && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!tick) begin
            check("tick_timeout", tick, 1);
        end
    endtask

    task automatic wait_tick();
        wait_tick_cycle();
        @(negedge clk);
    endtask

    initial begin
        int   accepted;
        int   first_low;
        int   first_high;
        int   ones;
        logic r;

        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 0);
        check("rst_underrun", underrun, 0);
        check("rst_dac", dac, 0);
        check("rst_tick", tick, 0);
        reset = 1'b1;
        check("rel_ready", asi_ready, 1);

        accepted   = 0;
        first_low  = -1;
        first_high = -1;
        asi_valid  = 1'b1;
        asi_data   = $urandom();
        for (int cyc = 0; cyc < 400 && accepted < 20; cyc++) begin
            r = asi_ready;
            if (cyc == 16) begin
                check("full_level", 32'(level), 16);
                check("full_accepted", accepted, 16);
            end
            if (!r && first_low < 0) first_low = cyc;
            if (r && first_low >= 0 && first_high < 0) first_high = cyc;
            @(negedge clk);
            if (r) begin
                accepted++;
                asi_data = $urandom();
            end
        end
        asi_valid = 1'b0;
        check("burst_accepted", accepted, 20);
        check("ready_low_cycle", first_low, 16);
        check("ready_back_cycle", first_high, 64);

        for (int k = 0; k < 30 && !underrun; k++) wait_tick();
        check("drain_underrun", underrun, 1);

        asi_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            asi_data = $urandom();
            @(negedge clk);
        end
        asi_valid = 1'b0;
        check("five_level", 32'(level), 5);
        #2 reset = 1'b0;
        #1;
        check("async_level", 32'(level), 0);
        check("async_dac", dac, 0);
        check("async_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rel_ready2", asi_ready, 1);

        asi_valid = 1'b1;
        asi_data  = 32'h1234_0000;
        @(negedge clk);
        asi_valid = 1'b0;
        wait_tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("zero_pattern", dac, i % 2);
        end

        asi_valid = 1'b1;
        asi_data  = 32'h0000_8000;
        @(negedge clk);
        asi_valid = 1'b0;
        wait_tick();
        ones = 0;
        repeat (60) begin
            @(negedge clk);
            ones += int'(dac);
        end
        check("min_ones", ones, 0);

        asi_valid = 1'b1;
        asi_data  = 32'h0000_7FFF;
        wait_tick();
        ones = 0;
        repeat (65536) begin
            @(negedge clk);
            ones += int'(dac);
        end
        asi_valid = 1'b0;
        check("max_ones", ones, 65535);

        for (int k = 0; k < 24 && !underrun; k++) wait_tick();
        check("empty_underrun", underrun, 1);
        ones = 0;
        repeat (60) begin
            @(negedge clk);
            ones += int'(dac);
        end
        check("midscale_ones", ones, 30);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_underrun", underrun, 0);
        wait_tick_cycle();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("set_wins", underrun, 1);

`ifdef DAC_UNDERRUN_CNT_EN
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("cnt_rst", ucnt, 0);
        repeat (3) wait_tick();
        check("cnt_three", ucnt, 3);
        wait_tick_cycle();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("cnt_clr_inc", ucnt, 1);
        #2 force dut.o_underrun_cnt = 16'hFFFE;
        #1 release dut.o_underrun_cnt;
        wait_tick();
        check("cnt_fffe_inc", ucnt, 16'hFFFF);
        wait_tick();
        check("cnt_sat", ucnt, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
